// File: rtl/bist_pkg.sv
// Shared types and defaults for the BIST controller.
// Holds the FSM encoding, default LFSR constants and counter width.
package bist_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    RUN,
    DRAIN,
    CHECK,
    DONE
  } state_e;

  localparam logic [31:0] DEF_POLY = 32'h04C1_1DB7;
  localparam logic [31:0] DEF_SEED = 32'h0000_0001;
  localparam int CNT_W = 16;

endpackage

// File: rtl/bist_lfsr.sv
// Galois shift register with parallel load and data injection.
// Used as pattern generator (data tied to 0) and as response MISR.
module bist_lfsr
  import bist_pkg::*;
#(
  parameter int W = 32,
  parameter logic [W-1:0] POLY = W'(DEF_POLY)
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         en_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic [W-1:0] data_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (load_i) begin
      q_d = load_val_i;
    end else if (en_i) begin
      q_d = {q_q[W-2:0], 1'b0}
          ^ (q_q[W-1] ? POLY : '0)
          ^ data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) q_q <= '0;
    else         q_q <= q_d;
  end

  assign q_o = q_q;

endmodule

// File: rtl/bist_ctrl.sv
// BIST run controller: arms on start_test, streams LFSR patterns,
// compacts responses in a MISR and reports a go/no-go verdict.
module bist_ctrl
  import bist_pkg::*;
#(
  parameter int unsigned PATTERN_COUNT = 1024,
  parameter logic [31:0] SEED          = DEF_SEED,
  parameter logic [31:0] POLY          = DEF_POLY,
  parameter logic [31:0] GOLDEN_SIG    = 32'hDEAD_BEEF,
  parameter int unsigned TIMEOUT       = 256
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_test,
  output logic        test_o,
  output logic        go_nogo,
  output logic        test_mode_o,
  output logic [31:0] pattern_o,
  output logic        pattern_valid_o,
  input  logic [31:0] response_i,
  input  logic        response_valid_i
);

  localparam logic [31:0] SEED_EFF =
    (SEED == 32'h0) ? 32'h1 : SEED;
  localparam logic [CNT_W-1:0] PAT_N =
    CNT_W'(PATTERN_COUNT);
  localparam logic [CNT_W-1:0] LAST_PAT =
    CNT_W'(PATTERN_COUNT - 1);
  localparam logic [CNT_W-1:0] LAST_DRN =
    CNT_W'(TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] pat_cnt_q, pat_cnt_d;
  logic [CNT_W-1:0] rsp_cnt_q, rsp_cnt_d;
  logic [CNT_W-1:0] drn_cnt_q, drn_cnt_d;
  logic             fail_q, fail_d;
  logic             go_q, go_d;
  logic             launch;
  logic             gen_en;
  logic             misr_en;
  logic [31:0]      misr_sig;

  always_comb begin
    state_d   = state_q;
    pat_cnt_d = pat_cnt_q;
    rsp_cnt_d = rsp_cnt_q;
    drn_cnt_d = drn_cnt_q;
    fail_d    = fail_q;
    go_d      = go_q;
    launch    = 1'b0;
    gen_en    = 1'b0;
    misr_en   = 1'b0;

    // responses only count while a run is in flight
    if ((state_q == RUN || state_q == DRAIN) &&
        response_valid_i) begin
      if (rsp_cnt_q < PAT_N) begin
        misr_en   = 1'b1;
        rsp_cnt_d = rsp_cnt_q + CNT_W'(1);
      end else begin
        fail_d = 1'b1;
      end
    end

    unique case (state_q)
      IDLE: begin
        if (start_test) state_d = ARMED;
      end
      ARMED: begin
        if (!start_test) begin
          state_d   = RUN;
          launch    = 1'b1;
          pat_cnt_d = '0;
          rsp_cnt_d = '0;
          drn_cnt_d = '0;
          fail_d    = 1'b0;
          go_d      = 1'b0;
        end
      end
      RUN: begin
        gen_en    = 1'b1;
        pat_cnt_d = pat_cnt_q + CNT_W'(1);
        if (pat_cnt_q == LAST_PAT) state_d = DRAIN;
      end
      DRAIN: begin
        drn_cnt_d = drn_cnt_q + CNT_W'(1);
        if (rsp_cnt_q == PAT_N) begin
          state_d = CHECK;
        end else if (drn_cnt_q == LAST_DRN) begin
          state_d = CHECK;
          fail_d  = 1'b1;
        end
      end
      CHECK: begin
        go_d    = (misr_sig == GOLDEN_SIG) && !fail_q;
        state_d = DONE;
      end
      DONE: begin
        if (start_test) state_d = ARMED;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      pat_cnt_q <= '0;
      rsp_cnt_q <= '0;
      drn_cnt_q <= '0;
      fail_q    <= 1'b0;
      go_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      pat_cnt_q <= pat_cnt_d;
      rsp_cnt_q <= rsp_cnt_d;
      drn_cnt_q <= drn_cnt_d;
      fail_q    <= fail_d;
      go_q      <= go_d;
    end
  end

  bist_lfsr #(.W(32), .POLY(POLY)) u_gen (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .en_i       (gen_en),
    .load_i     (launch),
    .load_val_i (SEED_EFF),
    .data_i     (32'h0),
    .q_o        (pattern_o)
  );

  bist_lfsr #(.W(32), .POLY(POLY)) u_misr (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .en_i       (misr_en),
    .load_i     (launch),
    .load_val_i (32'h0),
    .data_i     (response_i),
    .q_o        (misr_sig)
  );

  assign test_o = (state_q == ARMED) || (state_q == RUN) ||
                  (state_q == DRAIN) || (state_q == CHECK);
  assign test_mode_o     = (state_q == RUN) || (state_q == DRAIN);
  assign pattern_valid_o = (state_q == RUN);
  assign go_nogo         = go_q;

endmodule
